// File: rtl/multu_seq_rc.sv
// Sequential shift-add unsigned multiplier with a mod-3 residue self-check,
// an optional single recompute on mismatch and a saturating mismatch counter.
module multu_seq_rc #(
  parameter int unsigned W     = 4,
  parameter int unsigned RETRY = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic             fi_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-1:0]   p,
  output logic             err,
  output logic [7:0]       err_cnt
);

  localparam int unsigned CntW = $clog2(W);

  typedef enum logic [1:0] {StIdle, StCalc, StCheck, StDone} state_e;

  state_e            state_q, state_d;
  logic [W-1:0]      a_q, a_d, b_q, b_d;
  logic [1:0]        res_a_q, res_a_d, res_b_q, res_b_d;
  logic [2*W-1:0]    acc_q, acc_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              attempt_q, attempt_d;
  logic              err_q, err_d;
  logic [7:0]        err_cnt_q, err_cnt_d;

  logic [2*W-1:0]    partial;
  logic [1:0]        acc_mod, exp_mod;
  logic              mismatch;

  assign partial  = {{W{1'b0}}, a_q} << cnt_q;
  assign acc_mod  = 2'(32'(acc_q) % 32'd3);
  assign exp_mod  = 2'((32'(res_a_q) * 32'(res_b_q)) % 32'd3);
  assign mismatch = (acc_mod != exp_mod);

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    res_a_d   = res_a_q;
    res_b_d   = res_b_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    attempt_d = attempt_q;
    err_d     = err_q;
    err_cnt_d = err_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d       = a;
          b_d       = b;
          res_a_d   = 2'(32'(a) % 32'd3);
          res_b_d   = 2'(32'(b) % 32'd3);
          acc_d     = '0;
          cnt_d     = '0;
          attempt_d = 1'b0;
          state_d   = StCalc;
        end
      end
      StCalc: begin
        // Fault strobe flips bit 0 after this edge's partial-product add.
        acc_d = (b_q[cnt_q] ? acc_q + partial : acc_q) ^ {{(2*W-1){1'b0}}, fi_en};
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(W - 1)) begin
          state_d = StCheck;
        end
      end
      StCheck: begin
        if (!mismatch) begin
          err_d   = 1'b0;
          state_d = StDone;
        end else begin
          if (err_cnt_q != 8'hff) begin
            err_cnt_d = err_cnt_q + 8'd1;
          end
          if ((RETRY != 0) && !attempt_q) begin
            attempt_d = 1'b1;
            acc_d     = '0;
            cnt_d     = '0;
            state_d   = StCalc;
          end else begin
            err_d   = 1'b1;
            state_d = StDone;
          end
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      a_q       <= '0;
      b_q       <= '0;
      res_a_q   <= '0;
      res_b_q   <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      attempt_q <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      res_a_q   <= res_a_d;
      res_b_q   <= res_b_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      attempt_q <= attempt_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign p         = acc_q;
  assign err       = err_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_multu_seq_rc.sv
// Bench for multu_seq_rc: three instances (W=4/RETRY=1, W=4/RETRY=0, W=8/RETRY=1)
// checked against an arithmetic model of product, fault effect, retry and latency.
module tb_multu_seq_rc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_s[3];
  logic       in_valid_s[3], fi_s[3], out_ready_s[3];
  logic [7:0] a_s[3], b_s[3];
  logic       in_ready_s[3], out_valid_s[3], err_s[3];
  logic [7:0] ec_s[3];
  logic [7:0] p0, p1;
  logic [15:0] p2;

  int checks   = 0;
  int failures = 0;
  int ec_m[3];

  multu_seq_rc #(.W(4), .RETRY(1)) u0 (
    .clk(clk), .rst(rst_s[0]), .in_valid(in_valid_s[0]), .in_ready(in_ready_s[0]),
    .a(a_s[0][3:0]), .b(b_s[0][3:0]), .fi_en(fi_s[0]), .out_valid(out_valid_s[0]),
    .out_ready(out_ready_s[0]), .p(p0), .err(err_s[0]), .err_cnt(ec_s[0])
  );

  multu_seq_rc #(.W(4), .RETRY(0)) u1 (
    .clk(clk), .rst(rst_s[1]), .in_valid(in_valid_s[1]), .in_ready(in_ready_s[1]),
    .a(a_s[1][3:0]), .b(b_s[1][3:0]), .fi_en(fi_s[1]), .out_valid(out_valid_s[1]),
    .out_ready(out_ready_s[1]), .p(p1), .err(err_s[1]), .err_cnt(ec_s[1])
  );

  multu_seq_rc #(.W(8), .RETRY(1)) u2 (
    .clk(clk), .rst(rst_s[2]), .in_valid(in_valid_s[2]), .in_ready(in_ready_s[2]),
    .a(a_s[2]), .b(b_s[2]), .fi_en(fi_s[2]), .out_valid(out_valid_s[2]),
    .out_ready(out_ready_s[2]), .p(p2), .err(err_s[2]), .err_cnt(ec_s[2])
  );

  function automatic logic [31:0] p_of(input int u);
    if (u == 0) return {24'd0, p0};
    if (u == 1) return {24'd0, p1};
    return {16'd0, p2};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input int u, input string tag);
    check({tag, ".in_ready"}, 32'(in_ready_s[u]), 1);
    check({tag, ".out_valid"}, 32'(out_valid_s[u]), 0);
    check({tag, ".p"}, p_of(u), 0);
    check({tag, ".err"}, 32'(err_s[u]), 0);
    check({tag, ".err_cnt"}, 32'(ec_s[u]), 0);
  endtask

  // One full operation; mask bit i drives fi_en on the (i+1)-th CALC edge.
  task automatic run_op(input int u, input int av, input int bv, input int mask_in,
                        input int hold);
    int w, msk, prod, res1, n, lowc, exp_lat, exp_p, exp_err;
    bit mism;
    w    = (u == 2) ? 8 : 4;
    msk  = mask_in & ((1 << w) - 1);
    prod = av * bv;
    // Flipping bit 0 is invisible to later shifted adds, so only the flip parity matters.
    res1 = prod ^ ($countones(msk) & 1);
    mism = (res1 % 3) != (prod % 3);
    if (mism) ec_m[u] = (ec_m[u] < 255) ? ec_m[u] + 1 : 255;
    if (!mism) begin
      exp_p = res1; exp_err = 0; exp_lat = w + 1;
    end else if (u != 1) begin
      exp_p = prod; exp_err = 0; exp_lat = 2 * w + 2;
    end else begin
      exp_p = res1; exp_err = 1; exp_lat = w + 1;
    end

    @(negedge clk);
    in_valid_s[u] = 1'b1; a_s[u] = 8'(av); b_s[u] = 8'(bv);
    fi_s[u] = 1'b0; out_ready_s[u] = 1'b0;
    check("accept.in_ready", 32'(in_ready_s[u]), 1);
    @(posedge clk);
    @(negedge clk);
    in_valid_s[u] = 1'b0; a_s[u] = 8'($urandom); b_s[u] = 8'($urandom);
    fi_s[u] = msk[0];
    lowc = in_ready_s[u] ? 0 : 1;
    n = 0;
    while (!out_valid_s[u] && n < 40) begin
      // Inputs arriving mid-operation must be ignored.
      in_valid_s[u] = 1'($urandom);
      out_ready_s[u] = 1'($urandom);
      @(posedge clk);
      n++;
      @(negedge clk);
      fi_s[u] = (n < w) ? msk[n] : 1'b0;
      in_valid_s[u] = 1'b0;
      out_ready_s[u] = 1'b0;
      if (!in_ready_s[u]) lowc++;
    end
    check("latency", 32'(n), 32'(exp_lat));
    check("p", p_of(u), 32'(exp_p));
    check("err", 32'(err_s[u]), 32'(exp_err));
    check("err_cnt", 32'(ec_s[u]), 32'(ec_m[u]));
    for (int i = 0; i < hold; i++) begin
      in_valid_s[u] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("hold.p", p_of(u), 32'(exp_p));
      check("hold.out_valid", 32'(out_valid_s[u]), 1);
      if (!in_ready_s[u]) lowc++;
    end
    out_ready_s[u] = 1'b1; in_valid_s[u] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready_s[u] = 1'b0; in_valid_s[u] = 1'b0;
    check("consume.out_valid", 32'(out_valid_s[u]), 0);
    check("consume.in_ready", 32'(in_ready_s[u]), 1);
    check("busy_cycles", 32'(lowc), 32'(n + hold + 1));
  endtask

  initial begin
    int bad;
    for (int u = 0; u < 3; u++) begin
      rst_s[u] = 1'b1; in_valid_s[u] = 1'b0; fi_s[u] = 1'b0; out_ready_s[u] = 1'b0;
      a_s[u] = '0; b_s[u] = '0; ec_m[u] = 0;
    end
    #1;
    for (int u = 0; u < 3; u++) check_idle(u, "reset");
    @(negedge clk); @(negedge clk);
    for (int u = 0; u < 3; u++) rst_s[u] = 1'b0;

    run_op(0, 15, 15, 0, 0);
    run_op(0, 0, 9, 0, 0);
    run_op(0, 9, 0, 0, 0);
    run_op(0, 7, 3, 0, 10);
    run_op(0, 5, 6, 1, 0);
    run_op(1, 5, 6, 1, 0);
    run_op(1, 3, 3, 0, 0);
    run_op(2, 3, 5, 1, 0);

    for (int i = 0; i < 60; i++) begin
      int u, msk;
      u   = i % 3;
      msk = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 255)) : 0;
      run_op(u, int'($urandom_range(0, (u == 2) ? 255 : 15)),
             int'($urandom_range(0, (u == 2) ? 255 : 15)), msk, int'($urandom_range(0, 3)));
    end

    // Reset in the middle of CALC discards the operation.
    @(negedge clk);
    in_valid_s[2] = 1'b1; a_s[2] = 8'd200; b_s[2] = 8'd100;
    @(posedge clk);
    @(negedge clk);
    in_valid_s[2] = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_s[2] = 1'b1;
    #1 check_idle(2, "midcalc_rst");
    ec_m[2] = 0;
    @(negedge clk);
    rst_s[2] = 1'b0;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid_s[2] || !in_ready_s[2]) bad++;
    end
    check("post_rst.quiet", 32'(bad), 0);
    run_op(2, 255, 255, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multu_seq_rc.md
MULTU_SEQ_RC -- requirements
Module: multu_seq_rc

Interface
REQ-001 Parameter W, default 4, operand width in bits; legal range 2..16.
REQ-002 Parameter RETRY, default 1; 1 = one recompute on residue mismatch, 0 = no recompute.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  operand pair a/b valid.
REQ-006 in_ready  output  1  block can accept operands.
REQ-007 a  input  W  unsigned multiplicand.
REQ-008 b  input  W  unsigned multiplier.
REQ-009 fi_en  input  1  fault-injection strobe, for verification only.
REQ-010 out_valid  output  1  result p/err valid.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 p  output  2W  unsigned product a*b.
REQ-013 err  output  1  final result failed the mod-3 residue check.
REQ-014 err_cnt  output  8  saturating count of residue mismatches detected since reset.

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, CALC, CHECK, DONE.
REQ-016 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-017 Accept: an edge with IDLE, in_valid=1 latches a, b, res_a=a mod 3, res_b=b mod 3; clears accumulator and attempt flag; sets counter=0; enters CALC.
REQ-018 CALC: each edge, if bit[counter] of b is 1, adds a<<counter to the 2W-bit accumulator, then increments counter; after W edges enters CHECK.
REQ-019 Accumulator arithmetic SHALL be 2W bits wide and never overflow (max (2^W-1)^2).
REQ-020 fi_en=1 on a CALC edge SHALL XOR accumulator bit 0 after that edge's update; fi_en SHALL have no effect in other states.
REQ-021 CHECK (one edge): compare (res_a*res_b) mod 3 with accumulator mod 3.
REQ-022 Match -> DONE with err=0.
REQ-023 Mismatch, RETRY=1, first attempt -> set attempt flag, clear accumulator and counter, re-enter CALC with the latched operands.
REQ-024 Mismatch on second attempt, or RETRY=0 -> DONE with err=1.
REQ-025 Every mismatch SHALL increment err_cnt by 1; err_cnt SHALL saturate at 255.
REQ-026 Latency: accept edge k -> out_valid=1 after edge k+W+1 (fault-free); with one retry, after edge k+2W+2.
REQ-027 In DONE, p=accumulator and err SHALL hold stable until an edge with out_ready=1; that edge returns the FSM to IDLE.
REQ-028 No operand SHALL be accepted on the same edge a result is consumed; in_ready rises one cycle after that edge.
REQ-029 in_valid, a, b SHALL be ignored outside IDLE; out_ready SHALL be ignored outside DONE.

Reset
REQ-030 rst=1 SHALL immediately force: state=IDLE, in_ready=1, out_valid=0, p=0, err=0, err_cnt=0, counter=0, attempt flag=0.
REQ-031 rst asserted mid-CALC, mid-CHECK or in DONE SHALL discard the operation; no result is emitted after reset release.
REQ-032 The first accept after rst deassertion SHALL occur no earlier than the first rising edge with rst=0.

Verification
REQ-033 W=4: a=15, b=15, out_ready=1 -> out_valid after edge 5, p=225, err=0, err_cnt=0.
REQ-034 W=4: a=0, b=9 then a=9, b=0 -> p=0, err=0 each time; in_ready low for exactly 6 cycles per operation.
REQ-035 W=4: a=7, b=3, out_ready=0 for 10 cycles -> p=21 held stable, in_ready=0 throughout; consumed on the first out_ready=1 edge.
REQ-036 W=4, RETRY=1: a=5, b=6, fi_en=1 on first CALC edge only -> retry, p=30, err=0, err_cnt=1, out_valid after edge 10.
REQ-037 W=4, RETRY=0: a=5, b=6, fi_en=1 on one CALC edge -> p=31, err=1, err_cnt=1; a subsequent fault-free operation gives err=0, err_cnt=1.
REQ-038 W=8: rst pulsed at CALC edge 3 of a=200, b=100 -> out_valid stays 0, in_ready=1; next a=255, b=255 -> p=65025, err=0.
